// File: rtl/uart_pkg.sv
// Shared definitions for the uart register map, the ASCII control characters
// recognised by the hex loader, and the loader FSM state encoding.
package uart_pkg;

  localparam logic [3:0] REG_TX_RDY = 4'd0;
  localparam logic [3:0] REG_TX_DAT = 4'd1;
  localparam logic [3:0] REG_RX_RDY = 4'd2;
  localparam logic [3:0] REG_RX_DAT = 4'd3;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_AT    = 8'h40;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_POLL,
    ST_RX_CHK,
    ST_RX_READ,
    ST_RX_CAP,
    ST_PARSE,
    ST_TX_POLL,
    ST_TX_CHK,
    ST_TX_PUT,
    ST_DONE
  } state_e;

  function automatic logic is_sep(input logic [7:0] c);
    return (c == ASCII_SP) || (c == ASCII_CR) || (c == ASCII_LF) || (c == ASCII_COMMA);
  endfunction

endpackage

// File: rtl/hex_digit.sv
// Combinational ASCII hex digit decoder: 0-9, a-f, A-F map to a nibble with
// o_vld set; every other character gives o_vld=0 and a zero nibble.
module hex_digit (
  input  logic [7:0] i_ch,
  output logic       o_vld,
  output logic [3:0] o_nib
);

  logic [7:0] diff;

  always_comb begin
    o_vld = 1'b0;
    diff  = 8'h00;
    if (i_ch >= 8'h30 && i_ch <= 8'h39) begin
      o_vld = 1'b1;
      diff  = i_ch - 8'h30;
    end else if (i_ch >= 8'h61 && i_ch <= 8'h66) begin
      o_vld = 1'b1;
      diff  = i_ch - 8'h57;
    end else if (i_ch >= 8'h41 && i_ch <= 8'h46) begin
      o_vld = 1'b1;
      diff  = i_ch - 8'h37;
    end
    o_nib = diff[3:0];
  end

endmodule

// File: rtl/uart_hex_loader.sv
// Polls a uart register interface for ASCII hex, echoes accepted characters and
// writes assembled words to a sequential memory port until a '.' is received.
module uart_hex_loader
  import uart_pkg::*;
#(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_en,
  output logic               o_wr,
  output logic [3:0]         o_addr,
  output logic [7:0]         o_data,
  input  logic [7:0]         i_data,
  output logic               o_mem_wr,
  output logic [ADDR_SZ-1:0] o_mem_addr,
  output logic [DATA_SZ-1:0] o_mem_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int NDIG  = DATA_SZ / 4;
  localparam int CNT_W = $clog2(NDIG + 1);

  state_e             state_q, state_d;
  logic [DATA_SZ-1:0] acc_q, acc_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         ch_q, ch_d;
  logic               dot_q, dot_d;
  logic               err_q, err_d;

  logic               mem_wr_q, mem_wr_d;
  logic [ADDR_SZ-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_SZ-1:0] mem_data_q, mem_data_d;

  logic               en_q, en_d;
  logic               wr_q, wr_d;
  logic [3:0]         rsel_q, rsel_d;
  logic [7:0]         wdat_q, wdat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               hex_vld;
  logic [3:0]         hex_nib;

  hex_digit u_hex_digit (
    .i_ch  (ch_q),
    .o_vld (hex_vld),
    .o_nib (hex_nib)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    dot_d      = dot_q;
    err_d      = err_q;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          acc_d   = '0;
          addr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          dot_d   = 1'b0;
          state_d = ST_RX_POLL;
        end
      end
      ST_RX_POLL: state_d = ST_RX_CHK;
      ST_RX_CHK:  state_d = (i_data != 8'h00) ? ST_RX_READ : ST_RX_POLL;
      ST_RX_READ: state_d = ST_RX_CAP;
      ST_RX_CAP: begin
        ch_d    = i_data;
        state_d = ST_PARSE;
      end
      ST_PARSE: begin
        state_d = ST_TX_POLL;
        if (hex_vld) begin
          // Digits beyond the word width shift the oldest nibble out.
          acc_d = {acc_q[DATA_SZ-5:0], hex_nib};
          if (cnt_q != CNT_W'(NDIG)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (is_sep(ch_q) || ch_q == ASCII_DOT) begin
          if (cnt_q != '0) begin
            mem_wr_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = acc_q;
            addr_d     = addr_q + 1'b1;
          end
          acc_d = '0;
          cnt_d = '0;
          if (ch_q == ASCII_DOT) begin
            dot_d = 1'b1;
          end
        end else if (ch_q == ASCII_AT) begin
          if (cnt_q != '0) begin
            addr_d = acc_q[ADDR_SZ-1:0];
          end
          acc_d = '0;
          cnt_d = '0;
        end else begin
          err_d   = 1'b1;
          state_d = ST_RX_POLL;
        end
      end
      ST_TX_POLL: state_d = ST_TX_CHK;
      ST_TX_CHK:  state_d = (i_data != 8'h00) ? ST_TX_PUT : ST_TX_POLL;
      ST_TX_PUT:  state_d = dot_q ? ST_DONE : ST_RX_POLL;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state so they are registered and
  // line up with the cycle the FSM spends in the access state.
  always_comb begin
    en_d   = 1'b0;
    wr_d   = 1'b0;
    rsel_d = REG_TX_RDY;
    wdat_d = 8'h00;
    case (state_d)
      ST_RX_POLL: begin
        en_d   = 1'b1;
        rsel_d = REG_RX_RDY;
      end
      ST_RX_READ: begin
        en_d   = 1'b1;
        rsel_d = REG_RX_DAT;
      end
      ST_TX_POLL: begin
        en_d   = 1'b1;
        rsel_d = REG_TX_RDY;
      end
      ST_TX_PUT: begin
        en_d   = 1'b1;
        wr_d   = 1'b1;
        rsel_d = REG_TX_DAT;
        wdat_d = ch_q;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      ch_q       <= 8'h00;
      dot_q      <= 1'b0;
      err_q      <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
      rsel_q     <= 4'd0;
      wdat_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      dot_q      <= dot_d;
      err_q      <= err_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      en_q       <= en_d;
      wr_q       <= wr_d;
      rsel_q     <= rsel_d;
      wdat_q     <= wdat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_en       = en_q;
  assign o_wr       = wr_q;
  assign o_addr     = rsel_q;
  assign o_data     = wdat_q;
  assign o_mem_wr   = mem_wr_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule
